// File: rtl/imgwriter_pkg.sv
// Shared types and default widths for the frame-buffer writer.
package imgwriter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StBurst
    } state_e;

    localparam int unsigned DefAddressWidth = 24;
    localparam int unsigned DefLgFlen       = 11;
    localparam int unsigned DefBusW         = 32;
    localparam int unsigned DefLw           = 11;

endpackage

// File: rtl/imgwriter_sfifo.sv
// Synchronous first-word-fall-through FIFO; o_data always shows the head entry.
module imgwriter_sfifo #(
    parameter int unsigned DW     = 32,
    parameter int unsigned LGFLEN = 11
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_push,
    input  logic [DW-1:0]   i_data,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [DW-1:0]   o_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [LGFLEN:0] o_fill
);

    localparam int unsigned Depth = 1 << LGFLEN;

    logic [DW-1:0]   mem [Depth];
    logic [LGFLEN:0] wr_q, rd_q;
    logic            do_push, do_pop;

    // Fill never exceeds Depth, so its top bit alone marks full.
    assign o_fill  = wr_q - rd_q;
    assign o_full  = o_fill[LGFLEN];
    assign o_empty = (wr_q == rd_q);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_q[LGFLEN-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (LGFLEN+1)'(1);
            if (do_pop)  rd_q <= rd_q + (LGFLEN+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_q[LGFLEN-1:0]] <= i_data;
    end

endmodule

// File: rtl/imgwriter.sv
// Frame-buffer writer: buffers a pixel-word stream and bursts one line at a
// time into memory as a pipelined Wishbone write master.
module imgwriter
    import imgwriter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DefAddressWidth,
    parameter int unsigned LGFLEN        = DefLgFlen,
    parameter int unsigned BUSW          = DefBusW,
    parameter int unsigned LW            = DefLw
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_newframe,
    input  logic [ADDRESS_WIDTH-1:0] i_baseaddr,
    input  logic [LGFLEN:0]          i_linewords,
    input  logic [LW-1:0]            i_nlines,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [BUSW-1:0]          i_word,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
    output logic [BUSW-1:0]          o_wb_data,
    output logic [BUSW/8-1:0]        o_wb_sel,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_err,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_err
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned CW = LGFLEN + 1;
    localparam logic [CW-1:0] MaxWords = CW'(1) << LGFLEN;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   linewords_q, linewords_d;
    logic [LW-1:0]   nlines_q, nlines_d;
    logic [LW-1:0]   line_q, line_d;
    logic [CW-1:0]   stb_cnt_q, stb_cnt_d;
    logic [CW-1:0]   ack_cnt_q, ack_cnt_d;
    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [BUSW-1:0] fifo_data;
    logic [CW-1:0]   fifo_fill;
    logic            stb_accept;

    imgwriter_sfifo #(
        .DW     (BUSW),
        .LGFLEN (LGFLEN)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (fifo_push),
        .i_data    (i_word),
        .i_pop     (fifo_pop),
        .i_flush   (fifo_flush),
        .o_data    (fifo_data),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_fill    (fifo_fill)
    );

    // A word offered alongside i_newframe would be flushed, so refuse it.
    assign o_ready    = (state_q != StIdle) && !fifo_full && !i_newframe;
    assign fifo_push  = i_valid && o_ready;
    assign stb_accept = stb_q && !i_wb_stall;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        linewords_d = linewords_q;
        nlines_d    = nlines_q;
        line_d      = line_q;
        stb_cnt_d   = stb_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        err_d       = err_q;
        done_d      = 1'b0;
        fifo_flush  = 1'b0;
        fifo_pop    = 1'b0;

        if (i_newframe) begin
            addr_d      = i_baseaddr;
            linewords_d = i_linewords;
            nlines_d    = i_nlines;
            line_d      = '0;
            err_d       = 1'b0;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            fifo_flush  = 1'b1;
            if (i_linewords == '0 || i_nlines == '0) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else if (i_linewords > MaxWords) begin
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                state_d = StFill;
            end
        end else begin
            unique case (state_q)
                StIdle: ;
                StFill: begin
                    if (fifo_fill >= linewords_q) begin
                        state_d   = StBurst;
                        cyc_d     = 1'b1;
                        stb_d     = 1'b1;
                        stb_cnt_d = '0;
                        ack_cnt_d = '0;
                    end
                end
                StBurst: begin
                    if (i_wb_err) begin
                        cyc_d      = 1'b0;
                        stb_d      = 1'b0;
                        err_d      = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        if (stb_accept) begin
                            fifo_pop  = !fifo_empty;
                            addr_d    = addr_q + AW'(1);
                            stb_cnt_d = stb_cnt_q + CW'(1);
                            if (stb_cnt_q == linewords_q - CW'(1)) stb_d = 1'b0;
                        end
                        if (i_wb_ack) begin
                            if (ack_cnt_q == linewords_q - CW'(1)) begin
                                cyc_d  = 1'b0;
                                stb_d  = 1'b0;
                                line_d = line_q + LW'(1);
                                if (line_q + LW'(1) == nlines_q) begin
                                    state_d = StIdle;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = StFill;
                                end
                            end else begin
                                ack_cnt_d = ack_cnt_q + CW'(1);
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            linewords_q <= '0;
            nlines_q    <= '0;
            line_q      <= '0;
            stb_cnt_q   <= '0;
            ack_cnt_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            linewords_q <= linewords_d;
            nlines_q    <= nlines_d;
            line_q      <= line_d;
            stb_cnt_q   <= stb_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = 1'b1;
    assign o_wb_addr    = addr_q;
    assign o_wb_data    = fifo_data;
    assign o_wb_sel     = '1;
    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_imgwriter.sv
// Directed bench for imgwriter: stream feeder and Wishbone memory slave are
// modelled inside tick(), so all inputs are driven from the initial block.
module tb_imgwriter;

    localparam int unsigned AW     = 24;
    localparam int unsigned LGFLEN = 11;
    localparam int unsigned BUSW   = 32;
    localparam int unsigned LW     = 11;

    logic              clk = 1'b0;
    logic              i_reset_n, i_newframe, i_valid, o_ready;
    logic [AW-1:0]     i_baseaddr, o_wb_addr;
    logic [LGFLEN:0]   i_linewords;
    logic [LW-1:0]     i_nlines;
    logic [BUSW-1:0]   i_word, o_wb_data;
    logic              o_wb_cyc, o_wb_stb, o_wb_we;
    logic [BUSW/8-1:0] o_wb_sel;
    logic              i_wb_stall, i_wb_ack, i_wb_err;
    logic              o_busy, o_frame_done, o_err;

    always #5 clk = ~clk;

    imgwriter #(
        .ADDRESS_WIDTH (AW),
        .LGFLEN        (LGFLEN),
        .BUSW          (BUSW),
        .LW            (LW)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (i_reset_n),
        .i_newframe   (i_newframe),
        .i_baseaddr   (i_baseaddr),
        .i_linewords  (i_linewords),
        .i_nlines     (i_nlines),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_word       (i_word),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .o_wb_sel     (o_wb_sel),
        .i_wb_stall   (i_wb_stall),
        .i_wb_ack     (i_wb_ack),
        .i_wb_err     (i_wb_err),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_err        (o_err)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [BUSW-1:0] words[$];
    int              ack_due[$];
    logic [BUSW-1:0] mem [4096];
    logic [AW-1:0]   wlog[$];
    int stall_mode, valid_mode, delay_mode, err_at, ack_num;
    int cyc_rises, done_pulses, burst_acc, bad_bursts, exp_lw;
    logic cyc_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, note handshakes, cross the edge, then update models.
    task automatic tick();
        logic fire, acc;
        #1;
        fire = i_valid && o_ready;
        acc  = o_wb_cyc && o_wb_stb && !i_wb_stall;
        if (acc) begin
            mem[o_wb_addr[11:0]] = o_wb_data;
            wlog.push_back(o_wb_addr);
        end
        @(posedge clk);
        #1;
        cycle++;
        if (fire && words.size() > 0) void'(words.pop_front());
        if (acc) begin
            burst_acc++;
            ack_due.push_back(cycle + (delay_mode != 0 ? 1 + (cycle * 7) % 5 : 1));
        end
        if (!o_wb_cyc && cyc_prev && exp_lw != 0 && burst_acc != exp_lw) bad_bursts++;
        if (o_wb_cyc && !cyc_prev) begin
            cyc_rises++;
            burst_acc = 0;
        end
        if (o_frame_done) done_pulses++;
        cyc_prev = o_wb_cyc;

        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        if (!o_wb_cyc) begin
            ack_due.delete();
        end else if (ack_due.size() > 0 && ack_due[0] <= cycle + 1) begin
            void'(ack_due.pop_front());
            ack_num++;
            if (ack_num == err_at) begin
                i_wb_err = 1'b1;
                err_at   = 0;
            end else begin
                i_wb_ack = 1'b1;
            end
        end
        i_wb_stall = (stall_mode != 0) && ((cycle * 3) % 7 < 3);

        if (words.size() > 0) begin
            i_valid = (valid_mode != 0) ? ((cycle % 3) != 0) : 1'b1;
            i_word  = words[0];
        end else begin
            i_valid = 1'b0;
            i_word  = '0;
        end
        i_newframe = 1'b0;
    endtask

    task automatic prep(input int stall, input int bursty, input int dly, input int errn,
                        input int lw);
        stall_mode  = stall;
        valid_mode  = bursty;
        delay_mode  = dly;
        err_at      = errn;
        exp_lw      = lw;
        ack_num     = 0;
        cyc_rises   = 0;
        done_pulses = 0;
        bad_bursts  = 0;
        words.delete();
        wlog.delete();
    endtask

    task automatic newframe(input logic [AW-1:0] base, input int lw, input int nl);
        i_baseaddr  = base;
        i_linewords = lw[LGFLEN:0];
        i_nlines    = nl[LW-1:0];
        i_newframe  = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_frame_done && n < budget) begin
            tick();
            n++;
        end
        check({tag, " frame_done seen"}, 64'(o_frame_done), 64'd1);
    endtask

    initial begin
        i_reset_n = 1'b0; i_newframe = 1'b0; i_baseaddr = '0; i_linewords = '0;
        i_nlines = '0; i_valid = 1'b0; i_word = '0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        prep(0, 0, 0, 0, 0);
        #3;

        // Reset held for five cycles
        repeat (5) tick();
        check("rst cyc", 64'(o_wb_cyc), 64'd0);
        check("rst stb", 64'(o_wb_stb), 64'd0);
        check("rst addr", 64'(o_wb_addr), 64'd0);
        check("rst ready", 64'(o_ready), 64'd0);
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst done", 64'(o_frame_done), 64'd0);
        check("rst err", 64'(o_err), 64'd0);
        check("rst we", 64'(o_wb_we), 64'd1);
        check("rst sel", 64'(o_wb_sel), 64'hf);
        i_reset_n = 1'b1;
        tick();

        // Words offered while idle are refused
        for (int i = 0; i < 3; i++) words.push_back(32'h5555_0000 + i);
        repeat (4) tick();
        check("idle ready", 64'(o_ready), 64'd0);
        check("idle words kept", 64'(words.size()), 64'd3);

        // Two lines of four, no stall, ack one cycle late
        prep(0, 0, 0, 0, 4);
        for (int i = 0; i < 8; i++) words.push_back(32'hA000_0000 + i);
        newframe(24'h100, 4, 2);
        check("t2 busy", 64'(o_busy), 64'd1);
        wait_done("t2", 200);
        repeat (3) tick();
        check("t2 writes", 64'(wlog.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("t2 order", 64'(wlog[i]), 64'(24'h100 + i));
            check("t2 data", 64'(mem[12'h100 + i]), 64'(32'hA000_0000 + i));
        end
        check("t2 bursts", 64'(cyc_rises), 64'd2);
        check("t2 strobes per burst", 64'(bad_bursts), 64'd0);
        check("t2 done pulses", 64'(done_pulses), 64'd1);
        check("t2 idle", 64'(o_busy), 64'd0);

        // Same frame with stalls, late acks and bursty stream
        prep(1, 1, 1, 0, 4);
        for (int i = 0; i < 8; i++) words.push_back(32'hB000_0000 + i);
        newframe(24'h100, 4, 2);
        wait_done("t3", 400);
        repeat (6) tick();
        check("t3 writes", 64'(wlog.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            check("t3 data", 64'(mem[12'h100 + i]), 64'(32'hB000_0000 + i));
        check("t3 bursts", 64'(cyc_rises), 64'd2);
        check("t3 strobes per burst", 64'(bad_bursts), 64'd0);
        check("t3 done pulses", 64'(done_pulses), 64'd1);

        // Bus error on the second ack of line 0
        prep(0, 0, 0, 2, 0);
        for (int i = 0; i < 8; i++) words.push_back(32'hC000_0000 + i);
        newframe(24'h300, 4, 2);
        for (int n = 0; n < 200 && !o_err; n++) tick();
        check("t4 err set", 64'(o_err), 64'd1);
        check("t4 cyc dropped", 64'(o_wb_cyc), 64'd0);
        check("t4 idle", 64'(o_busy), 64'd0);
        prep(0, 0, 0, 0, 4);
        for (int i = 0; i < 4; i++) words.push_back(32'hC100_0000 + i);
        newframe(24'h300, 4, 1);
        check("t4 err cleared", 64'(o_err), 64'd0);
        wait_done("t4", 200);
        check("t4 first addr", 64'(wlog[0]), 64'h300);
        for (int i = 0; i < 4; i++)
            check("t4 data", 64'(mem[12'h300 + i]), 64'(32'hC100_0000 + i));

        // New frame mid-burst
        prep(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) words.push_back(32'hD000_0000 + i);
        newframe(24'h400, 4, 2);
        for (int n = 0; n < 200 && wlog.size() < 2; n++) tick();
        check("t5 mid burst", 64'(o_wb_cyc && wlog.size() >= 2), 64'd1);
        words.delete();
        newframe(24'h200, 4, 1);
        check("t5 cyc dropped", 64'(o_wb_cyc), 64'd0);
        wlog.delete();
        for (int i = 0; i < 4; i++) words.push_back(32'hE000_0000 + i);
        wait_done("t5", 200);
        check("t5 writes", 64'(wlog.size()), 64'd4);
        check("t5 first addr", 64'(wlog[0]), 64'h200);
        for (int i = 0; i < 4; i++)
            check("t5 data", 64'(mem[12'h200 + i]), 64'(32'hE000_0000 + i));

        // Degenerate and oversized frames
        prep(0, 0, 0, 0, 0);
        newframe(24'h500, 0, 3);
        check("t6 zero done", 64'(o_frame_done), 64'd1);
        tick();
        check("t6 zero done pulse", 64'(o_frame_done), 64'd0);
        repeat (5) tick();
        check("t6 zero no cyc", 64'(cyc_rises), 64'd0);
        check("t6 zero idle", 64'(o_busy), 64'd0);
        for (int i = 0; i < 4; i++) words.push_back(32'hF000_0000 + i);
        newframe(24'h500, (1 << LGFLEN) + 1, 1);
        check("t6 big err", 64'(o_err), 64'd1);
        check("t6 big idle", 64'(o_busy), 64'd0);
        repeat (10) tick();
        check("t6 big no cyc", 64'(cyc_rises), 64'd0);
        check("t6 big ready", 64'(o_ready), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
